max_score_tracker: RTL and testbench

//   Downstream consumer of the per-cell max unit outputs across the PE array. Each beat carries one

---
 rtl/design_variables_pkg.sv | 19 +
 rtl/max_score_tracker_lane_max_tree.sv | 52 +++++
 rtl/max_score_tracker.sv | 173 +++++++++++++++++
 tb/tb_max_score_tracker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_variables_pkg.sv
// Shared types and constants for the score datapath and the max-score tracker.
package design_variables;

  localparam int SCORE_WIDTH_MAX = 16;
  localparam int DRAIN_CYCLES    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tracker_state_t;

  typedef struct packed {
    logic [SCORE_WIDTH_MAX-1:0] score;
    logic [1:0]                 source;
  } cell_result_t;

endpackage

// File: rtl/max_score_tracker_lane_max_tree.sv
// Combinational max-reduction over one beat of lane results; invalid lanes never win,
// ties resolve to the lowest lane index.
module lane_max_tree
  import design_variables::*;
#(
  parameter int N_LANES = 8,
  parameter int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [N_LANES-1:0]       lane_vld,
  input  cell_result_t [N_LANES-1:0] lane_res,
  output logic                     best_vld,
  output cell_result_t             best_res,
  output logic [IDX_W-1:0]         best_idx
);

  localparam int LEAVES = 1 << $clog2(N_LANES);
  localparam int NODES  = 2 * LEAVES - 1;

  logic         n_vld [NODES];
  cell_result_t n_res [NODES];
  logic [IDX_W-1:0] n_idx [NODES];

  // Heap layout: node k has children 2k+1 (lower lanes) and 2k+2 (higher lanes).
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      n_vld[k] = 1'b0;
      n_res[k] = '0;
      n_idx[k] = '0;
    end
    for (int i = 0; i < N_LANES; i++) begin
      n_vld[LEAVES-1+i] = lane_vld[i];
      n_res[LEAVES-1+i] = lane_res[i];
      n_idx[LEAVES-1+i] = IDX_W'(i);
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (n_vld[2*k+2] && (!n_vld[2*k+1] || (n_res[2*k+2].score > n_res[2*k+1].score))) begin
        n_vld[k] = 1'b1;
        n_res[k] = n_res[2*k+2];
        n_idx[k] = n_idx[2*k+2];
      end else begin
        n_vld[k] = n_vld[2*k+1];
        n_res[k] = n_res[2*k+1];
        n_idx[k] = n_idx[2*k+1];
      end
    end
  end

  assign best_vld = n_vld[0];
  assign best_res = n_res[0];
  assign best_idx = n_idx[0];

endmodule

// File: rtl/max_score_tracker.sv
// Tracks the best local-alignment score over a matrix fill and hands one result to traceback.
// Pipeline: stage 1 registers the per-beat lane winner, stage 2 is the running-best register.
module max_score_tracker
  import design_variables::*;
#(
  parameter int N_LANES = 8,
  parameter int ROW_W   = 10,
  parameter int COL_W   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               in_ready,
  input  logic                               in_valid,
  input  logic [N_LANES-1:0]                 in_lane_vld,
  input  logic [N_LANES*SCORE_WIDTH_MAX-1:0] in_score,
  input  logic [N_LANES*2-1:0]               in_source,
  input  logic [ROW_W-1:0]                   in_row,
  input  logic [COL_W-1:0]                   in_col,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SCORE_WIDTH_MAX-1:0]         out_score,
  output logic [ROW_W-1:0]                   out_row,
  output logic [COL_W-1:0]                   out_col,
  output logic [1:0]                         out_source,
  output logic                               out_found,
  output logic                               busy
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and out_valid holds with stable data until taken.

  tracker_state_t state, state_next;
  logic [1:0]     drain_cnt;
  logic           clear;
  logic           accept;

  cell_result_t [N_LANES-1:0] lane_res;
  logic                       tree_vld;
  cell_result_t               tree_res;
  logic [IDX_W-1:0]           tree_idx;

  logic                       s1_vld;
  cell_result_t               s1_res;
  logic [ROW_W-1:0]           s1_row;
  logic [COL_W-1:0]           s1_col;

  logic [SCORE_WIDTH_MAX-1:0] best_score;
  logic [ROW_W-1:0]           best_row;
  logic [COL_W-1:0]           best_col;
  logic [1:0]                 best_src;
  logic                       best_found;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      lane_res[i].score  = in_score[i*SCORE_WIDTH_MAX +: SCORE_WIDTH_MAX];
      lane_res[i].source = in_source[2*i +: 2];
    end
  end

  lane_max_tree #(.N_LANES(N_LANES), .IDX_W(IDX_W)) u_tree (
    .lane_vld (in_lane_vld),
    .lane_res (lane_res),
    .best_vld (tree_vld),
    .best_res (tree_res),
    .best_idx (tree_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start that lands together with a beat in ACCUM wins: the beat belongs to the aborted matrix.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
          clear      = 1'b1;
        end
      end
      ACCUM: begin
        if (start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (in_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          state_next = ACCUM;
          clear      = 1'b1;
        end else if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) drain_cnt <= '0;
    else                       drain_cnt <= drain_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_vld <= 1'b0;
      s1_res <= '0;
      s1_row <= '0;
      s1_col <= '0;
    end else begin
      s1_vld <= accept && tree_vld;
      if (accept) begin
        s1_res <= tree_res;
        s1_row <= in_row + ROW_W'(tree_idx);
        s1_col <= in_col - COL_W'(tree_idx);
      end
    end
  end

  // Strict compare against a zero-initialised best: earlier beats keep ties, zero never registers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_score <= '0;
      best_row   <= '0;
      best_col   <= '0;
      best_src   <= '0;
      best_found <= 1'b0;
    end else if (s1_vld && (s1_res.score > best_score)) begin
      best_score <= s1_res.score;
      best_row   <= s1_row;
      best_col   <= s1_col;
      best_src   <= s1_res.source;
      best_found <= 1'b1;
    end
  end

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign out_score  = best_score;
  assign out_row    = best_row;
  assign out_col    = best_col;
  assign out_source = best_src;
  assign out_found  = best_found;

`ifndef SYNTHESIS
  logic pos_wrap;
  always_comb begin
    pos_wrap = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (in_lane_vld[i] && ((int'(in_row) + i > (1 << ROW_W) - 1) || (int'(in_col) < i)))
        pos_wrap = 1'b1;
    end
  end

  a_no_pos_wrap: assert property (@(posedge clk) disable iff (rst) accept |-> !pos_wrap)
    else $error("max_score_tracker: lane position wraps around the row/col range");
`endif

endmodule

// File: tb/tb_max_score_tracker.sv
// Randomized bench for max_score_tracker: a flat cell-list model picks the expected best per matrix.
module tb_max_score_tracker;
  import design_variables::*;

  localparam int N     = 8;
  localparam int SW    = SCORE_WIDTH_MAX;
  localparam int ROW_W = 10;
  localparam int COL_W = 10;
  localparam int RES_W = 1 + SW + ROW_W + COL_W + 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_ready;
  logic              in_valid;
  logic [N-1:0]      in_lane_vld;
  logic [N*SW-1:0]   in_score;
  logic [N*2-1:0]    in_source;
  logic [ROW_W-1:0]  in_row;
  logic [COL_W-1:0]  in_col;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_score;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic [1:0]        out_source;
  logic              out_found;
  logic              busy;

  max_score_tracker #(.N_LANES(N), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .in_valid(in_valid),
    .in_lane_vld(in_lane_vld), .in_score(in_score), .in_source(in_source),
    .in_row(in_row), .in_col(in_col), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_score(out_score), .out_row(out_row), .out_col(out_col),
    .out_source(out_source), .out_found(out_found), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int score;
    int src;
    int row;
    int col;
  } cell_t;

  cell_t              cells[$];
  logic [RES_W-1:0]   exp_q[$];

  logic [N-1:0] b_vld;
  int           b_score [N];
  int           b_src   [N];

  // Best cell = first cell in arrival order (beat, then lane) holding the largest non-zero score.
  task automatic model_close();
    int bs, br, bc, bsrc;
    bit f;
    bs = 0; br = 0; bc = 0; bsrc = 0; f = 1'b0;
    foreach (cells[k]) begin
      if (cells[k].score > bs) begin
        bs = cells[k].score; br = cells[k].row; bc = cells[k].col; bsrc = cells[k].src; f = 1'b1;
      end
    end
    exp_q.push_back({f, SW'(bs), ROW_W'(br), COL_W'(bc), 2'(bsrc)});
    cells.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cells.delete();
  endtask

  task automatic drive_beat(input int row, input int col, input bit last);
    cell_t c;
    for (int i = 0; i < N; i++) begin
      in_score[i*SW +: SW] = SW'(b_score[i]);
      in_source[2*i +: 2]  = 2'(b_src[i]);
      if (b_vld[i]) begin
        c.score = b_score[i]; c.src = b_src[i]; c.row = row + i; c.col = col - i;
        cells.push_back(c);
      end
    end
    in_lane_vld = b_vld;
    in_row      = ROW_W'(row);
    in_col      = COL_W'(col);
    in_valid    = 1'b1;
    in_last     = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap();
    in_last = 1'($urandom_range(0, 1));
    tick();
    in_last = 1'b0;
  endtask

  task automatic rand_lanes(input int max_score);
    b_vld = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < N; i++) begin
      b_score[i] = $urandom_range(0, max_score);
      b_src[i]   = $urandom_range(0, 3);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_valid", tag), out_valid, 0);
    check($sformatf("%s_found", tag), out_found, 0);
    check($sformatf("%s_score", tag), out_score, 0);
    check($sformatf("%s_row", tag), out_row, 0);
    check($sformatf("%s_col", tag), out_col, 0);
    check($sformatf("%s_src", tag), out_source, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_in_ready", tag), in_ready, 0);
  endtask

  // Entered one cycle after the in_last beat was accepted (cycle T+1).
  task automatic check_result(input string tag, input int hold, input bit pulse_start);
    logic [RES_W-1:0] e;
    int waited;
    e = exp_q.pop_front();
    check($sformatf("%s_lat_t1", tag), out_valid, 0);
    tick();
    check($sformatf("%s_lat_t2", tag), out_valid, 0);
    tick();
    check($sformatf("%s_lat_t3", tag), out_valid, 1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    for (int h = 0; h <= hold; h++) begin
      check($sformatf("%s_valid_h%0d", tag, h), out_valid, 1);
      check($sformatf("%s_found_h%0d", tag, h), out_found, 32'(e[RES_W-1]));
      check($sformatf("%s_score_h%0d", tag, h), out_score, 32'(e[ROW_W+COL_W+2 +: SW]));
      check($sformatf("%s_row_h%0d", tag, h), out_row, 32'(e[COL_W+2 +: ROW_W]));
      check($sformatf("%s_col_h%0d", tag, h), out_col, 32'(e[2 +: COL_W]));
      check($sformatf("%s_src_h%0d", tag, h), out_source, 32'(e[1:0]));
      if (h < hold) begin
        start = pulse_start && (h == hold / 2);
        tick();
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    start     = pulse_start;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check($sformatf("%s_post_valid", tag), out_valid, 0);
    check($sformatf("%s_post_busy", tag), busy, 0);
    check($sformatf("%s_post_in_ready", tag), in_ready, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_lane_vld = '0; in_score = '0; in_source = '0; in_row = '0; in_col = '0;
    b_vld = '0;
    for (int i = 0; i < N; i++) begin b_score[i] = 0; b_src[i] = 0; end
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Reset in the middle of accumulation with a partial best of 37.
    do_start();
    b_vld = 8'h04;
    for (int i = 0; i < N; i++) begin b_score[i] = (i == 2) ? 37 : 0; b_src[i] = 1; end
    drive_beat(4, 12, 1'b0);
    tick();
    tick();
    check($sformatf("t1_busy_pre"), busy, 1);
    rst = 1'b1;
    tick();
    check_zero("t1_rst");
    rst = 1'b0;
    cells.delete();
    tick();

    // Scores {3,9,9,1} at row 4 col 12: lane 1 wins the tie.
    do_start();
    b_vld = '1;
    b_score = '{3, 9, 9, 1, 0, 0, 0, 0};
    b_src   = '{1, 2, 3, 1, 0, 0, 0, 0};
    drive_beat(4, 12, 1'b1);
    model_close();
    check_result("t2", 0, 1'b0);

    // Equal best in two beats: the earlier beat keeps its position.
    do_start();
    b_vld = '1;
    b_score = '{5, 1, 2, 20, 4, 0, 3, 7};
    b_src   = '{0, 1, 2, 3, 0, 1, 2, 3};
    drive_beat(10, 20, 1'b0);
    gap();
    b_score = '{20, 6, 20, 0, 1, 2, 3, 4};
    b_src   = '{1, 1, 1, 1, 1, 1, 1, 1};
    drive_beat(30, 40, 1'b1);
    model_close();
    check_result("t3", 1, 1'b0);

    // Only zero scores on valid lanes; large scores sit on invalid lanes.
    do_start();
    b_vld = 8'hF0;
    b_score = '{99, 99, 99, 99, 0, 0, 0, 0};
    b_src   = '{3, 3, 3, 3, 2, 2, 2, 2};
    drive_beat(5, 20, 1'b0);
    b_vld = '0;
    b_score = '{50, 50, 50, 50, 50, 50, 50, 50};
    drive_beat(6, 21, 1'b1);
    model_close();
    check_result("t4", 0, 1'b0);

    // Result held for 5 cycles without out_ready while start is pulsed.
    do_start();
    rand_lanes(30);
    b_vld[0] = 1'b1;
    b_score[0] = 12;
    drive_beat(100, 200, 1'b1);
    model_close();
    check_result("t5", 5, 1'b1);

    // Start re-pulsed during the drain after a best of 50.
    do_start();
    b_vld = '1;
    b_score = '{1, 50, 2, 3, 4, 5, 6, 7};
    b_src   = '{0, 1, 2, 3, 0, 1, 2, 3};
    drive_beat(50, 60, 1'b1);
    do_start();
    b_score = '{2, 7, 0, 7, 1, 3, 5, 6};
    b_src   = '{3, 2, 1, 0, 3, 2, 1, 0};
    drive_beat(70, 80, 1'b0);
    rand_lanes(7);
    drive_beat(71, 81, 1'b1);
    model_close();
    check_result("t6", 0, 1'b0);

    // Random matrices with gaps, stray beats in IDLE and variable result stalls.
    for (int m = 0; m < 30; m++) begin
      if ($urandom_range(0, 2) == 0) begin
        rand_lanes(255);
        for (int i = 0; i < N; i++) in_score[i*SW +: SW] = SW'(b_score[i]);
        in_lane_vld = '1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
      end
      do_start();
      for (int b = $urandom_range(1, 6); b > 0; b--) begin
        rand_lanes((m % 3 == 0) ? 3 : 40);
        drive_beat($urandom_range(0, (1 << ROW_W) - N), $urandom_range(N - 1, (1 << COL_W) - 1), b == 1);
        if (b > 1 && $urandom_range(0, 1) == 1) gap();
      end
      model_close();
      check_result($sformatf("rnd%0d", m), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
